// File: rtl/if_pc_gen.sv
// Fetch-stage next-PC generator.
// Drives pc to BTB/IMEM and registers the fetched PC into IF/ID.
module if_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [31:0]      btb_target_pc,
  input  logic             btb_valid,
  input  logic             btb_predicted_taken,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_redirect_pc,
  output logic [31:0]      pc,
  output logic             if_id_valid,
  output logic [31:0]      if_id_pc,
  output logic             if_id_pred_taken,
  output logic [31:0]      if_id_pred_target,
  output logic [CNT_W-1:0] pred_taken_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REFILL
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } if_id_t;

  localparam if_id_t BUBBLE = '0;

  state_t          state_q;
  logic [31:0]     pc_q;
  if_id_t          if_id_q;
  logic [CNT_W-1:0] ptc_q;
  logic [CNT_W-1:0] mpc_q;

  logic        pred_hit;
  logic [31:0] pred_pc;
  logic [31:0] redir_pc;
  logic [31:0] seq_pc;

  // Low address bits are dropped: fetch is word aligned.
  logic unused_low_bits;
  assign unused_low_bits = &{1'b0, btb_target_pc[1:0],
                             ex_redirect_pc[1:0]};

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c
  );
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Candidate next PCs and the BTB taken decision.
  always_comb begin
    pred_hit = btb_valid & btb_predicted_taken;
    pred_pc  = {btb_target_pc[31:2], 2'b00};
    redir_pc = {ex_redirect_pc[31:2], 2'b00};
    seq_pc   = pc_q + 32'd4;
  end

  // PC, IF/ID, mode and statistics; redirect > stall > hit > seq.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      if_id_q <= BUBBLE;
      ptc_q   <= '0;
      mpc_q   <= '0;
    end else begin
      unique case (state_q)
        BOOT: begin
          state_q <= RUN;
          if_id_q <= BUBBLE;
        end
        RUN, REFILL: begin
          if (ex_redirect) begin
            state_q <= REFILL;
            pc_q    <= redir_pc;
            if_id_q <= BUBBLE;
            mpc_q   <= sat_inc(mpc_q);
          end else if (stall) begin
            state_q <= state_q;
          end else if (pred_hit) begin
            state_q        <= RUN;
            pc_q           <= pred_pc;
            if_id_q.valid  <= 1'b1;
            if_id_q.pc     <= pc_q;
            if_id_q.taken  <= 1'b1;
            if_id_q.target <= pred_pc;
            ptc_q          <= sat_inc(ptc_q);
          end else begin
            state_q        <= RUN;
            pc_q           <= seq_pc;
            if_id_q.valid  <= 1'b1;
            if_id_q.pc     <= pc_q;
            if_id_q.taken  <= 1'b0;
            if_id_q.target <= 32'h0;
          end
        end
        default: begin
          state_q <= BOOT;
          if_id_q <= BUBBLE;
        end
      endcase
    end
  end

  assign pc                = pc_q;
  assign if_id_valid       = if_id_q.valid;
  assign if_id_pc          = if_id_q.pc;
  assign if_id_pred_taken  = if_id_q.taken;
  assign if_id_pred_target = if_id_q.target;
  assign pred_taken_cnt    = ptc_q;
  assign mispredict_cnt    = mpc_q;

endmodule

// File: tb/tb_if_pc_gen.sv
// Bench for if_pc_gen: vector table plus saturation/reset sequences.
// Expected outputs travel through a scoreboard queue.
module tb_if_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] btb_target_pc;
  logic        btb_valid;
  logic        btb_predicted_taken;
  logic        ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic [31:0] pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic        if_id_pred_taken;
  logic [31:0] if_id_pred_target;
  logic [3:0]  pred_taken_cnt;
  logic [3:0]  mispredict_cnt;

  if_pc_gen #(
    .RESET_PC(32'h0000_0000),
    .CNT_W   (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .btb_target_pc      (btb_target_pc),
    .btb_valid          (btb_valid),
    .btb_predicted_taken(btb_predicted_taken),
    .ex_redirect        (ex_redirect),
    .ex_redirect_pc     (ex_redirect_pc),
    .pc                 (pc),
    .if_id_valid        (if_id_valid),
    .if_id_pc           (if_id_pc),
    .if_id_pred_taken   (if_id_pred_taken),
    .if_id_pred_target  (if_id_pred_target),
    .pred_taken_cnt     (pred_taken_cnt),
    .mispredict_cnt     (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        bv;
    logic        bt;
    logic [31:0] bpc;
    logic        rd;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic        e_v;
    logic [31:0] e_ipc;
    logic        e_tk;
    logic [31:0] e_tg;
    logic [3:0]  e_ptc;
    logic [3:0]  e_mpc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec;
  int   n_bad;

  function automatic vec_t mk(
    input logic r, input logic s, input logic bv,
    input logic bt, input logic [31:0] bpc,
    input logic rd, input logic [31:0] rpc,
    input logic [31:0] e_pc, input logic e_v,
    input logic [31:0] e_ipc, input logic e_tk,
    input logic [31:0] e_tg, input logic [3:0] e_ptc,
    input logic [3:0] e_mpc
  );
    vec_t v;
    v.rst = r; v.stall = s; v.bv = bv; v.bt = bt;
    v.bpc = bpc; v.rd = rd; v.rpc = rpc;
    v.e_pc = e_pc; v.e_v = e_v; v.e_ipc = e_ipc;
    v.e_tk = e_tk; v.e_tg = e_tg;
    v.e_ptc = e_ptc; v.e_mpc = e_mpc;
    return v;
  endfunction

  task automatic cmp(input string nm, input int idx,
                     input logic [31:0] got,
                     input logic [31:0] want);
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @vec%0d: got %h want %h",
               nm, idx, got, want);
    end
  endtask

  // Drive one cycle of inputs, push expectation, compare after edge.
  task automatic apply(input vec_t v);
    vec_t e;
    rst                 = v.rst;
    stall               = v.stall;
    btb_valid           = v.bv;
    btb_predicted_taken = v.bt;
    btb_target_pc       = v.bpc;
    ex_redirect         = v.rd;
    ex_redirect_pc      = v.rpc;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp("pc", n_vec, pc, e.e_pc);
    cmp("if_id_valid", n_vec, 32'(if_id_valid), 32'(e.e_v));
    if (e.e_v) begin
      cmp("if_id_pc", n_vec, if_id_pc, e.e_ipc);
      cmp("if_id_pred_taken", n_vec,
          32'(if_id_pred_taken), 32'(e.e_tk));
      cmp("if_id_pred_target", n_vec,
          if_id_pred_target, e.e_tg);
    end
    cmp("pred_taken_cnt", n_vec,
        32'(pred_taken_cnt), 32'(e.e_ptc));
    cmp("mispredict_cnt", n_vec,
        32'(mispredict_cnt), 32'(e.e_mpc));
    n_vec++;
  endtask

  initial begin
    logic [31:0] prev_pc;
    int          cnt;
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1; stall = 1'b0;
    btb_valid = 1'b0; btb_predicted_taken = 1'b0;
    btb_target_pc = '0;
    ex_redirect = 1'b0; ex_redirect_pc = '0;
    #1;

    // reset, boot bubble, sequential fetch
    tbl.push_back(mk(1,0,0,0,0,0,0, 32'h0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 32'h0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 32'h4,1,32'h0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 32'h8,1,32'h4,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 32'hC,1,32'h8,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0, 32'h10,1,32'hC,0,0,0,0));
    // predicted taken and the two half-hit boundary cases
    tbl.push_back(mk(0,0,1,1,32'h40,0,0,
                     32'h40,1,32'h10,1,32'h40,1,0));
    tbl.push_back(mk(0,0,1,0,32'h80,0,0,
                     32'h44,1,32'h40,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,32'h80,0,0,
                     32'h48,1,32'h44,0,0,1,0));
    // misaligned BTB target is forced to a word boundary
    tbl.push_back(mk(0,0,1,1,32'h23,0,0,
                     32'h20,1,32'h48,1,32'h20,2,0));
    // three stalled cycles with a BTB hit present
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,1,1,32'h80,0,0,
                       32'h20,1,32'h48,1,32'h20,2,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     32'h24,1,32'h20,0,0,2,0));
    // redirect beats stall and a BTB hit
    tbl.push_back(mk(0,1,1,1,32'h80,1,32'h103,
                     32'h100,0,0,0,0,2,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     32'h104,1,32'h100,0,0,2,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     32'h108,1,32'h104,0,0,2,1));
    // stall during refill holds the bubble
    tbl.push_back(mk(0,0,0,0,0,1,32'h140,
                     32'h140,0,0,0,0,2,2));
    tbl.push_back(mk(0,1,0,0,0,0,0,
                     32'h140,0,0,0,0,2,2));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     32'h144,1,32'h140,0,0,2,2));
    // back-to-back redirects
    tbl.push_back(mk(0,0,0,0,0,1,32'h200,
                     32'h200,0,0,0,0,2,3));
    tbl.push_back(mk(0,0,0,0,0,1,32'h300,
                     32'h300,0,0,0,0,2,4));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     32'h304,1,32'h300,0,0,2,4));
    // wrap at the top of the address space
    tbl.push_back(mk(0,0,0,0,0,1,32'hFFFF_FFFE,
                     32'hFFFF_FFFC,0,0,0,0,2,5));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     32'h0,1,32'hFFFF_FFFC,0,0,2,5));
    tbl.push_back(mk(0,0,0,0,0,0,0,
                     32'h4,1,32'h0,0,0,2,5));

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i]);

    // pred_taken_cnt climbs from 2 and saturates at 15
    prev_pc = 32'h4;
    cnt     = 2;
    for (int i = 0; i < 15; i++) begin
      cnt = (cnt < 15) ? cnt + 1 : 15;
      apply(mk(0,0,1,1,32'h600,0,0,
               32'h600,1,prev_pc,1,32'h600,
               4'(cnt),5));
      prev_pc = 32'h600;
    end

    // mispredict_cnt climbs from 5 and saturates at 15
    cnt = 5;
    for (int i = 0; i < 12; i++) begin
      cnt = (cnt < 15) ? cnt + 1 : 15;
      apply(mk(0,0,0,0,0,1,32'h500,
               32'h500,0,0,0,0,15,4'(cnt)));
    end

    // reset overrides redirect, stall and a hit
    apply(mk(1,1,1,1,32'h80,1,32'h700,
             32'h0,0,0,0,0,0,0));
    // boot cycle ignores redirect and stall
    apply(mk(0,1,0,0,0,1,32'h700,
             32'h0,0,0,0,0,0,0));
    apply(mk(0,0,0,0,0,0,0,
             32'h4,1,32'h0,0,0,0,0));

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: got %0d left want 0",
               sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
